// File: rtl/scan_test_pkg.sv
// scan_test_pkg: shared types and defaults for the scan-test controller.
package scan_test_pkg;
  localparam int CHAIN_LEN_DEF = 8;
  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, FINISH} state_t;
endpackage

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: load/capture/unload scan controller with masked response compare.
module scan_test_ctrl
  import scan_test_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 so,
  output logic                 se,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 match
);
  localparam int CW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [CHAIN_LEN-1:0] pat, exp_r, msk, resp_nx;
  logic last;
  assign last = cnt == LAST;
  assign resp_nx = {response[CHAIN_LEN-2:0], so};
  always_comb begin
    state_nx = state;
    se = 1'b0;
    si = 1'b0;
    busy = state != IDLE;
    done = state == FINISH;
    case (state)
      IDLE: state_nx = start ? LOAD : IDLE;
      LOAD: begin
        se = 1'b1;
        si = pat[LAST - cnt];
        state_nx = last ? CAPTURE : LOAD;
      end
      CAPTURE: state_nx = UNLOAD;
      UNLOAD: begin
        se = 1'b1;
        state_nx = last ? FINISH : UNLOAD;
      end
      default: state_nx = IDLE;
    endcase
  end
  // counter restarts on every state entry and is held at zero while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pat <= '0;
      exp_r <= '0;
      msk <= '0;
      response <= '0;
      match <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state_nx != state || state == IDLE) ? '0 : cnt + CW'(1);
      if (state == IDLE && start) begin
        pat <= pattern;
        exp_r <= expected;
        msk <= mask;
        response <= '0;
        match <= 1'b0;
      end
      if (state == UNLOAD) begin
        response <= resp_nx;
        if (last) match <= ((resp_nx ^ exp_r) & msk) == '0;
      end
    end
  end
endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl: directed bench driving three controllers (N=4, 2, 16) into bench-modelled SDFF chains.
module tb_scan_test_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0, sel = 4;
  logic [3:0] pat4, exp4, msk4, di4, ch4, resp4;
  logic [1:0] pat2, exp2, msk2, di2, ch2, resp2;
  logic [15:0] pat16, exp16, msk16, di16, ch16, resp16;
  logic se4, si4, busy4, done4, match4;
  logic se2, si2, busy2, done2, match2;
  logic se16, si16, busy16, done16, match16;
  scan_test_ctrl #(.CHAIN_LEN(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .pattern(pat4),
    .expected(exp4), .mask(msk4), .so(ch4[3]), .se(se4), .si(si4), .busy(busy4), .done(done4),
    .response(resp4), .match(match4));
  scan_test_ctrl #(.CHAIN_LEN(2)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .pattern(pat2),
    .expected(exp2), .mask(msk2), .so(ch2[1]), .se(se2), .si(si2), .busy(busy2), .done(done2),
    .response(resp2), .match(match2));
  scan_test_ctrl #(.CHAIN_LEN(16)) u16 (.clk(clk), .rst_n(rst_n), .start(start), .pattern(pat16),
    .expected(exp16), .mask(msk16), .so(ch16[15]), .se(se16), .si(si16), .busy(busy16), .done(done16),
    .response(resp16), .match(match16));
  // SDFF chains: flop 0 takes SI, flop i takes flop i-1, DI on capture
  always_ff @(posedge clk) begin
    ch4 <= se4 ? {ch4[2:0], si4} : di4;
    ch2 <= se2 ? {ch2[0], si2} : di2;
    ch16 <= se16 ? {ch16[14:0], si16} : di16;
  end
  logic obs_se, obs_si, obs_busy, obs_done, obs_match;
  logic [15:0] obs_resp, obs_chain;
  always_comb begin
    obs_se = sel == 2 ? se2 : sel == 16 ? se16 : se4;
    obs_si = sel == 2 ? si2 : sel == 16 ? si16 : si4;
    obs_busy = sel == 2 ? busy2 : sel == 16 ? busy16 : busy4;
    obs_done = sel == 2 ? done2 : sel == 16 ? done16 : done4;
    obs_match = sel == 2 ? match2 : sel == 16 ? match16 : match4;
    obs_resp = sel == 2 ? 16'(resp2) : sel == 16 ? resp16 : 16'(resp4);
    obs_chain = sel == 2 ? 16'(ch2) : sel == 16 ? ch16 : 16'(ch4);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  // start must already be high; returns the edge index (after E0) whose following cycle shows DONE
  task automatic go(input int n, input bit noise, input int rst_at, input logic [15:0] pat,
                    output int lat, output int se_low_k, output int se_low_cnt);
    lat = 0;
    se_low_k = -1;
    se_low_cnt = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 3 * n + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) chk("resp_cleared", obs_resp, 0);
      if (k == n) chk("chain_loaded", obs_chain, pat);
      if (!obs_se && !obs_done) begin
        se_low_cnt++;
        se_low_k = k;
      end
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", obs_busy, 0);
        chk("async_se", obs_se, 0);
        chk("async_resp", obs_resp, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lat = -1;
        break;
      end
      if (obs_done) begin
        lat = k;
        start = noise;
        break;
      end
      start = noise && (k == 2 || k == n + 3);
    end
  endtask
  int lat, slk, slc, dones;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    di4 = 4'b1010; pat4 = 4'b0110; exp4 = 4'b1010; msk4 = 4'b1111;
    di2 = 2'b10; pat2 = 2'b01; exp2 = 2'b10; msk2 = 2'b11;
    pat16 = 16'hA5C3; di16 = ~16'hA5C3; exp16 = 16'h5A3C; msk16 = 16'hFFFF;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_se", obs_se, 0);
    chk("rst_si", obs_si, 0);
    chk("rst_busy", obs_busy, 0);
    chk("rst_done", obs_done, 0);
    chk("rst_resp", obs_resp, 0);
    chk("rst_match", obs_match, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    go(4, 0, 0, 16'h6, lat, slk, slc);
    chk("basic_lat", lat, 9);
    chk("basic_se_low_cnt", slc, 1);
    chk("basic_se_low_at", slk, 4);
    chk("basic_resp", obs_resp, 16'hA);
    chk("basic_match", obs_match, 1);
    repeat (2) @(negedge clk);
    chk("idle_hold_resp", obs_resp, 16'hA);
    exp4 = 4'b1011;
    start = 1'b1;
    go(4, 0, 0, 16'h6, lat, slk, slc);
    chk("mism_resp", obs_resp, 16'hA);
    chk("mism_match", obs_match, 0);
    repeat (2) @(negedge clk);
    msk4 = 4'b1110;
    start = 1'b1;
    go(4, 0, 0, 16'h6, lat, slk, slc);
    chk("masked_match", obs_match, 1);
    repeat (2) @(negedge clk);
    exp4 = 4'b1010; msk4 = 4'b1111;
    start = 1'b1;
    go(4, 1, 0, 16'h6, lat, slk, slc);
    chk("noise_lat", lat, 9);
    chk("noise_resp", obs_resp, 16'hA);
    chk("noise_match", obs_match, 1);
    @(negedge clk);
    chk("finish_start_ignored", obs_busy, 0);
    chk("done_one_cycle", obs_done, 0);
    go(4, 0, 0, 16'h6, lat, slk, slc);
    chk("restart_lat", lat, 9);
    repeat (2) @(negedge clk);
    start = 1'b1;
    go(4, 0, 7, 16'h6, lat, slk, slc);
    chk("reset_aborted", lat, -1);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (obs_done) dones++;
    end
    chk("no_done_after_reset", dones, 0);
    di4 = 4'b0011; exp4 = 4'b0011;
    start = 1'b1;
    go(4, 0, 0, 16'h6, lat, slk, slc);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_resp", obs_resp, 16'h3);
    chk("post_rst_match", obs_match, 1);
    repeat (40) @(negedge clk);
    sel = 2;
    start = 1'b1;
    go(2, 0, 0, 16'h1, lat, slk, slc);
    chk("n2_lat", lat, 5);
    chk("n2_se_low_at", slk, 2);
    chk("n2_resp", obs_resp, 16'h2);
    chk("n2_match", obs_match, 1);
    repeat (40) @(negedge clk);
    sel = 16;
    start = 1'b1;
    go(16, 0, 0, 16'hA5C3, lat, slk, slc);
    chk("n16_lat", lat, 33);
    chk("n16_se_low_cnt", slc, 1);
    chk("n16_resp", obs_resp, 16'h5A3C);
    chk("n16_match", obs_match, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
